// File: rtl/seq_pattern_scheduler.sv
// Round-robin scheduler that shares one serial pattern output among NUM_REQ requesters.
// Optional feature macro: SEQ_SCHED_PARITY_EN appends an even-parity bit to every frame.
module seq_pattern_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int PAT_W   = 9,
    parameter int REP_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*PAT_W-1:0]   pattern_in,
    input  logic [NUM_REQ*REP_W-1:0]   reps_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       serial_out,
    output logic                       bit_valid,
    output logic                       frame_done,
    output logic                       burst_done,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic [1:0]                 state_out
);

    localparam int ID_W = $clog2(NUM_REQ);
`ifdef SEQ_SCHED_PARITY_EN
    localparam int FRAME_LEN = PAT_W + 1;
`else
    localparam int FRAME_LEN = PAT_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

`ifdef SEQ_SCHED_PARITY_EN
    function automatic logic even_parity(input logic [PAT_W-1:0] v);
        return ^v;
    endfunction
`endif

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [PAT_W-1:0]     pat_q, pat_d;
    logic [PAT_W-1:0]     shreg_q, shreg_d;
    logic [REP_W-1:0]     reps_q, reps_d;
    logic [REP_W-1:0]     rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 serial_q, serial_d;
    logic                 valid_q, valid_d;
    logic                 fd_q, fd_d;
    logic                 bd_q, bd_d;
    logic [ID_W-1:0]      owner_q, owner_d;

    logic                 win_found_s;
    logic [ID_W-1:0]      win_idx_s;
    logic [ID_W-1:0]      cand_s;
    logic [PAT_W-1:0]     win_pat_s;
    logic [REP_W-1:0]     win_reps_s;
    logic                 last_rep_s;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign win_pat_s  = pattern_in[win_idx_s*PAT_W +: PAT_W];
    assign win_reps_s = reps_in[win_idx_s*REP_W +: REP_W];
    assign last_rep_s = (rep_cnt_q == reps_q - REP_W'(1));

    // Next-state and next-output logic; outputs are precomputed so they leave registers.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        owner_d   = owner_q;
        grant_d   = '0;
        busy_d    = 1'b0;
        serial_d  = 1'b0;
        valid_d   = 1'b0;
        fd_d      = 1'b0;
        bd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d   = ST_SEND;
                    rr_d      = win_idx_s;
                    owner_d   = win_idx_s;
                    pat_d     = win_pat_s;
                    shreg_d   = {win_pat_s[PAT_W-2:0], 1'b0};
                    reps_d    = (win_reps_s == '0) ? REP_W'(1) : win_reps_s;
                    rep_cnt_d = '0;
                    bit_cnt_d = '0;
                    grant_d   = NUM_REQ'(1) << win_idx_s;
                    busy_d    = 1'b1;
                    serial_d  = win_pat_s[PAT_W-1];
                    valid_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    if (!last_rep_s) begin
                        // Back-to-back frame: no idle bit between repeats.
                        shreg_d   = {pat_q[PAT_W-2:0], 1'b0};
                        serial_d  = pat_q[PAT_W-1];
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    valid_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    fd_d      = (bit_cnt_q == CNT_W'(FRAME_LEN - 2));
                    bd_d      = (bit_cnt_q == CNT_W'(FRAME_LEN - 2)) && last_rep_s;
`ifdef SEQ_SCHED_PARITY_EN
                    if (bit_cnt_q == CNT_W'(PAT_W - 1)) begin
                        serial_d = even_parity(pat_q);
                    end else begin
                        serial_d = shreg_q[PAT_W-1];
                        shreg_d  = {shreg_q[PAT_W-2:0], 1'b0};
                    end
`else
                    serial_d = shreg_q[PAT_W-1];
                    shreg_d  = {shreg_q[PAT_W-2:0], 1'b0};
`endif
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= ID_W'(NUM_REQ - 1);
            pat_q     <= '0;
            shreg_q   <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            serial_q  <= 1'b0;
            valid_q   <= 1'b0;
            fd_q      <= 1'b0;
            bd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            serial_q  <= serial_d;
            valid_q   <= valid_d;
            fd_q      <= fd_d;
            bd_q      <= bd_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign bit_valid  = valid_q;
    assign frame_done = fd_q;
    assign burst_done = bd_q;
    assign owner_id   = owner_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_seq_pattern_scheduler.sv
// Self-checking bench for seq_pattern_scheduler: vector table of bursts plus hand-written
// sequences for latching and mid-frame reset; expected cycles are queued and popped per cycle.
module tb_seq_pattern_scheduler;

    localparam int NUM_REQ = 4;
    localparam int PAT_W   = 9;
    localparam int REP_W   = 4;
`ifdef SEQ_SCHED_PARITY_EN
    localparam int FL = PAT_W + 1;
`else
    localparam int FL = PAT_W;
`endif

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic       serial;
        logic       valid;
        logic       fd;
        logic       bd;
        logic [1:0] owner;
        logic [1:0] state;
    } obs_t;

    typedef struct {
        logic [3:0] req;
        logic [8:0] pat;
        logic [3:0] reps;
        int         exp_owner;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*PAT_W-1:0] pattern_in;
    logic [NUM_REQ*REP_W-1:0] reps_in;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     serial_out;
    logic                     bit_valid;
    logic                     frame_done;
    logic                     burst_done;
    logic [1:0]               owner_id;
    logic [1:0]               state_out;

    obs_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    string  cur_name = "init";
    vec_t   vecs[10];

    seq_pattern_scheduler #(.NUM_REQ(NUM_REQ), .PAT_W(PAT_W), .REP_W(REP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .pattern_in (pattern_in),
        .reps_in    (reps_in),
        .grant      (grant),
        .busy       (busy),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .frame_done (frame_done),
        .burst_done (burst_done),
        .owner_id   (owner_id),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pat_of(input logic [8:0] base, input int i);
        return base ^ 9'(i * 73);
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.grant  = grant;
        a.busy   = busy;
        a.serial = serial_out;
        a.valid  = bit_valid;
        a.fd     = frame_done;
        a.bd     = burst_done;
        a.owner  = owner_id;
        a.state  = state_out;
        return a;
    endfunction

    task automatic drive(input logic [3:0] r, input logic [8:0] base, input logic [3:0] rp);
        req = r;
        for (int i = 0; i < NUM_REQ; i++) begin
            pattern_in[i*PAT_W +: PAT_W] = pat_of(base, i);
            reps_in[i*REP_W +: REP_W]    = rp;
        end
    endtask

    // Expected per-cycle outputs of one whole burst, its GAP cycle and the following IDLE cycle.
    task automatic push_burst(input int own, input logic [8:0] pat, input int reps);
        obs_t e;
        for (int f = 0; f < reps; f++) begin
            for (int b = 0; b < FL; b++) begin
                e.grant = (f == 0 && b == 0) ? 4'(1 << own) : 4'b0000;
                e.busy  = 1'b1;
                e.valid = 1'b1;
                if (b < PAT_W) e.serial = pat[PAT_W-1-b];
                else           e.serial = ^pat;
                e.fd    = (b == FL - 1);
                e.bd    = (b == FL - 1) && (f == reps - 1);
                e.owner = 2'(own);
                e.state = 2'd1;
                exp_q.push_back(e);
            end
        end
        e = '{grant: 4'b0000, busy: 1'b1, serial: 1'b0, valid: 1'b0, fd: 1'b0, bd: 1'b0,
              owner: 2'(own), state: 2'd2};
        exp_q.push_back(e);
        e.busy  = 1'b0;
        e.state = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic tick_check();
        obs_t e;
        obs_t a;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got grant=%b busy=%b ser=%b val=%b fd=%b bd=%b own=%0d st=%0d expected grant=%b busy=%b ser=%b val=%b fd=%b bd=%b own=%0d st=%0d",
                         cur_name, cyc, a.grant, a.busy, a.serial, a.valid, a.fd, a.bd, a.owner, a.state,
                         e.grant, e.busy, e.serial, e.valid, e.fd, e.bd, e.owner, e.state);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick_check();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d expected cycles left, required 0", cur_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string nm);
        obs_t a;
        a = sample();
        checks++;
        if (a !== obs_t'(0)) begin
            errors++;
            $display("FAIL %s outputs got %h required 0", nm, a);
        end
    endtask

    initial begin
        // Reps field 0 must act as a single frame; rr pointer walks 0,1,2,3,0 under full load.
        vecs[0] = '{4'b1111, 9'b100111001, 4'd1, 0};
        vecs[1] = '{4'b1111, 9'b010110011, 4'd1, 1};
        vecs[2] = '{4'b1111, 9'b111000101, 4'd1, 2};
        vecs[3] = '{4'b1111, 9'b001101110, 4'd1, 3};
        vecs[4] = '{4'b1111, 9'b100111001, 4'd1, 0};
        vecs[5] = '{4'b0001, 9'b100111001, 4'd3, 0};
        vecs[6] = '{4'b0100, 9'b110011010, 4'd0, 2};
        vecs[7] = '{4'b1010, 9'b011110001, 4'd2, 3};
        vecs[8] = '{4'b1010, 9'b101010101, 4'd1, 1};
        vecs[9] = '{4'b0110, 9'b000000011, 4'd1, 2};

        req        = '0;
        pattern_in = '0;
        reps_in    = '0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            cur_name = $sformatf("vec%0d", v);
            drive(vecs[v].req, vecs[v].pat, vecs[v].reps);
            push_burst(vecs[v].exp_owner, pat_of(vecs[v].pat, vecs[v].exp_owner),
                       (vecs[v].reps == 4'd0) ? 1 : int'(vecs[v].reps));
            drain(400);
        end
        req = '0;

        // Pattern and reps changed right after the grant must not affect the burst.
        cur_name = "latch";
        drive(4'b0001, 9'b110100101, 4'd2);
        push_burst(0, 9'b110100101, 2);
        tick_check();
        pattern_in = ~pattern_in;
        reps_in    = {4{4'd1}};
        req        = '0;
        drain(100);

        // Reset in the middle of a frame, then requester 0 must win first.
        cur_name = "rst_mid";
        drive(4'b0010, 9'b101101011, 4'd1);
        push_burst(1, pat_of(9'b101101011, 1), 1);
        repeat (5) tick_check();
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_mid_zero");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur_name = "after_rst";
        drive(4'b1111, 9'b001011100, 4'd1);
        push_burst(0, pat_of(9'b001011100, 0), 1);
        drain(100);
        req = '0;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_scheduler.md
# seq_pattern_scheduler

Round-robin scheduler that shares one serial pattern output among NUM_REQ requesters. Each requester presents a PAT_W-bit pattern and a repeat count. The block grants one requester at a time and shifts that pattern out MSB-first for the requested number of frames. It sits in front of the serial sequence-output pin and replaces fixed hard-wired sequence generators with a programmable, shared resource.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- PAT_W, 9, pattern length in bits (2..32)
- REP_W, 4, width of each repeat-count field

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request level
- pattern_in  input  NUM_REQ*PAT_W  requester i pattern at bits [i*PAT_W +: PAT_W]
- reps_in  input  NUM_REQ*REP_W  requester i frame count at bits [i*REP_W +: REP_W]; 0 is treated as 1
- grant  output  NUM_REQ  one-hot, one-cycle acknowledge
- busy  output  1  high in SEND and GAP
- serial_out  output  1  current serial bit
- bit_valid  output  1  serial_out carries a pattern (or parity) bit
- frame_done  output  1  pulse on the last bit of each frame
- burst_done  output  1  pulse on the last bit of the last frame
- owner_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
- state_out  output  2  IDLE=0, SEND=1, GAP=2

## Operation
- All outputs are registered. There is no combinational path from inputs to outputs.
- **IDLE**
  - If any req bit is high at a rising edge, pick the winner round-robin, starting at (last_owner+1) mod NUM_REQ.
  - At that edge: latch the winner's pattern and reps, load shift register, bit_cnt=0, rep_cnt=0, owner_id=winner, and enter SEND.
  - If no req bit is high, stay in IDLE.
- **SEND**
  - One bit per cycle, MSB first. serial_out = shreg[PAT_W-1], bit_valid=1.
  - On the last bit of a frame: frame_done=1. Then either:
    - rep_cnt < reps-1: reload the latched pattern and increment rep_cnt, with no gap between frames; or
    - last frame: burst_done=1, then go to GAP.
- **GAP**
  - One cycle: serial_out=0, bit_valid=0, busy=1. Then go to IDLE.
- **Handshake**
  - A requester holds req until it sees grant.
  - Dropping req before grant withdraws the request.
  - pattern_in and reps_in only need to be stable at the grant edge. Changes during SEND are ignored.
  - Keeping req high after burst_done re-queues the requester behind the others.
- **Round-robin pointer:** updated to the winner at each grant. After reset it equals NUM_REQ-1, so requester 0 has first priority.
- **Reset:** asserting rst at any time, including mid-frame, immediately clears state to IDLE and drives every output to 0. The in-progress burst is abandoned and not resumed.

## Timing
- req sampled high at edge T0 in IDLE → grant[winner] high for the cycle T0..T0+1, coinciding with the first bit on serial_out.
- Burst length is PAT_W*reps cycles, or (PAT_W+1)*reps with parity enabled.
- frame_done is high on cycles PAT_W, 2*PAT_W, … counted from grant.
- GAP follows one cycle after burst_done. The earliest next grant is at the edge ending GAP+1 (IDLE is one cycle minimum).
- Minimum turnaround between bursts: 2 idle cycles (GAP, IDLE).
- Reset values:
  - Outputs: grant=0, busy=0, serial_out=0, bit_valid=0, frame_done=0, burst_done=0, owner_id=0, state_out=0.
  - Internal: rr pointer=NUM_REQ-1.

## Configuration
- SEQ_SCHED_PARITY_EN defined:
  - After the PAT_W pattern bits of each frame, one extra bit is sent: the even parity (XOR) of the pattern, with bit_valid=1.
  - frame_done moves onto the parity bit.
  - Frame length is PAT_W+1.
- SEQ_SCHED_PARITY_EN undefined: frames are exactly PAT_W bits and no parity logic is present.

## Test plan
- After reset, req=4'b0001, pattern0=9'b100111001, reps0=1 → grant=0001 for 1 cycle; serial_out 1,0,0,1,1,1,0,0,1 on consecutive cycles with bit_valid=1; frame_done and burst_done on the 9th bit; then GAP (state_out=2), then IDLE.
- reps0=3, same pattern → 27 contiguous valid bits (the pattern three times); frame_done on bits 9, 18, 27; burst_done only on bit 27.
- req=4'b1111 held, all reps=1 → grants in order 0,1,2,3,0; owner_id follows; each burst is separated by exactly 2 non-valid cycles.
- reps_in=0 for requester 2 → exactly one frame is sent. pattern_in changed mid-burst → the output still shows the latched pattern.
- rst pulsed at bit 5 of a frame → all outputs are 0 within the same cycle; after release, the first grant goes to requester 0 if req[0]=1.
- With SEQ_SCHED_PARITY_EN, pattern 9'b100111001 (five 1s) → 10th bit = 1 with frame_done on it; pattern 9'b000000011 → 10th bit = 0.
